// File: rtl/ascii_uart_pkg.sv
`default_nettype none
// ============================================================================
// ascii_uart_pkg : shared transmitter state encoding and baud divisor helper
// Revision 1.0
// ============================================================================
package ascii_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Integer truncation; no fractional baud correction is applied.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_uart_tx_char_fifo.sv
`default_nettype none
// ============================================================================
// char_fifo : synchronous byte FIFO, push on full allowed when popping too
// Revision 1.0
// ============================================================================
module char_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk_100mhz,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [7:0]                     wdata,
    output logic [7:0]                     rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_next;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ascii_uart_tx.sv
`default_nettype none
// ============================================================================
// ascii_uart_tx : queues typed ASCII codes and sends them as 8N1 UART frames
// Revision 1.0
// ============================================================================
module ascii_uart_tx
    import ascii_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                 clk_100mhz,
    input  logic                                 rst_n,
    input  logic [7:0]                           char_in,
    input  logic                                 char_valid,
    output logic                                 tx,
    output logic                                 busy,
    output logic                                 fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 overflow
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int          BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t      state;
    tx_state_t      state_next;
    logic           pop;
    logic           tx_next;
    logic           fifo_empty;
    logic [7:0]     head;
    logic [7:0]     shift;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] baud_cnt;
    logic           baud_last;

    assign baud_last = (baud_cnt == BCW'(CLKS_PER_BIT - 1));

    char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .push       (char_valid),
        .pop        (pop),
        .wdata      (char_in),
        .rdata      (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and line level; STOP chains straight into START when data waits.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_last) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_last && (bit_cnt == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (pop) begin
            shift    <= head;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (state != IDLE) begin
            baud_cnt <= baud_last ? '0 : baud_cnt + BCW'(1);
            if ((state == DATA) && baud_last) begin
                shift   <= {1'b0, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // tx and busy are registered so the pin is glitch-free; both trail the FSM by one clock.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tx   <= tx_next;
            busy <= (state != IDLE) || (fifo_count != '0);
            if (char_valid && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascii_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_ascii_uart_tx : checks three transmitter instances against a frame-level model
// Revision 1.0
// ============================================================================
module tb_ascii_uart_tx;

    localparam int CPB_S = 10;                        // 100 Hz / 10 baud
    localparam int FL    = 10 * CPB_S;
    localparam int CPB_D = 100_000_000 / 115200;      // 868
    localparam int CPB_B = 100_000_000 / 9600;        // 10416

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data_s = '0, data_d = '0, data_b = '0;
    logic       push_s = 1'b0, push_d = 1'b0, push_b = 1'b0;
    logic       tx_s, busy_s, full_s, ovf_s;
    logic       tx_d, busy_d, full_d, ovf_d;
    logic       tx_b, busy_b, full_b, ovf_b;
    logic [3:0] cnt_s, cnt_d, cnt_b;

    always #5 clk = ~clk;

    ascii_uart_tx #(.CLK_HZ(100), .BAUD(10), .FIFO_DEPTH(8)) dut_s (
        .clk_100mhz(clk), .rst_n(rst_n), .char_in(data_s), .char_valid(push_s),
        .tx(tx_s), .busy(busy_s), .fifo_full(full_s), .fifo_count(cnt_s), .overflow(ovf_s));

    ascii_uart_tx dut_d (
        .clk_100mhz(clk), .rst_n(rst_n), .char_in(data_d), .char_valid(push_d),
        .tx(tx_d), .busy(busy_d), .fifo_full(full_d), .fifo_count(cnt_d), .overflow(ovf_d));

    ascii_uart_tx #(.BAUD(9600)) dut_b (
        .clk_100mhz(clk), .rst_n(rst_n), .char_in(data_b), .char_valid(push_b),
        .tx(tx_b), .busy(busy_b), .fifo_full(full_b), .fifo_count(cnt_b), .overflow(ovf_b));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model for dut_s: a byte queue plus the start edge of the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] m_cur = '0;
    int         m_fs = -1000000;
    logic       m_ovf = 1'b0, m_prev_active = 1'b0;
    int         m_prev_cnt = 0;
    logic       m_tx = 1'b1, m_busy = 1'b0;
    logic       in_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        int idx;
        idx = j / CPB_S;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fs = -1000000;
        m_ovf = 1'b0;
        m_prev_active = 1'b0;
        m_prev_cnt = 0;
        m_tx = 1'b1;
        m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic [7:0] d);
        int  j;
        logic pop;
        j      = (cyc - 1) - m_fs;
        m_tx   = (j >= 0 && j < FL) ? frame_bit(m_cur, j) : 1'b1;
        m_busy = m_prev_active || (m_prev_cnt != 0);
        pop    = (cyc >= m_fs + FL) && (mq.size() > 0);
        if (pop) begin
            m_cur = mq.pop_front();
            m_fs  = cyc;
        end
        if (p) begin
            if (mq.size() < 8) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        m_prev_active = (cyc - m_fs) < FL;
        m_prev_cnt    = mq.size();
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(push_s, data_s);
        #1;
        push_s = 1'b0;
        push_d = 1'b0;
        push_b = 1'b0;
        chk("tx_s", 32'(tx_s), 32'(m_tx));
        chk("busy_s", 32'(busy_s), 32'(m_busy));
        chk("count_s", 32'(cnt_s), 32'(mq.size()));
        chk("full_s", 32'(full_s), 32'(mq.size() == 8));
        chk("overflow_s", 32'(ovf_s), 32'(m_ovf));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        in_rst = 1'b1;
        #1;
        model_reset();
        chk("rst_tx_s", 32'(tx_s), 32'd1);
        chk("rst_busy_s", 32'(busy_s), 32'd0);
        chk("rst_count_s", 32'(cnt_s), 32'd0);
        chk("rst_ovf_s", 32'(ovf_s), 32'd0);
        chk("rst_full_s", 32'(full_s), 32'd0);
        chk("rst_tx_d", 32'(tx_d), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
        in_rst = 1'b0;
    endtask

    typedef struct {
        int   off;
        logic tx;
        logic busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int e, t0, t1, t2, peak, target;
        logic [7:0] a_bits;

        // 'A' on the default instance: offsets from the push edge E.
        a_bits = 8'h41;
        vecs[0] = '{1, 1'b1, 1'b1};
        vecs[1] = '{2, 1'b0, 1'b1};
        for (int b = 0; b < 10; b++)
            vecs[2+b] = '{2 + b*CPB_D + CPB_D/2,
                          (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : a_bits[b-1], 1'b1};
        vecs[12] = '{2 + 10*CPB_D - 1, 1'b1, 1'b1};
        vecs[13] = '{2 + 10*CPB_D,     1'b1, 1'b0};

        #1;
        do_reset(3);

        data_d = 8'h41;
        push_d = 1'b1;
        step();
        e = cyc;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 20000 && cyc < e + vecs[i].off; k++) step();
            chk($sformatf("A_tx[%0d]", vecs[i].off), 32'(tx_d), 32'(vecs[i].tx));
            chk($sformatf("A_busy[%0d]", vecs[i].off), 32'(busy_d), 32'(vecs[i].busy));
        end

        // 9600 baud: measure start-bit and first data-bit lengths (0x55 toggles each bit).
        data_b = 8'h55;
        push_b = 1'b1;
        step();
        e = cyc;
        t0 = -1; t1 = -1; t2 = -1;
        for (int i = 0; i < 20; i++) begin step(); if (tx_b == 1'b0) begin t0 = cyc; break; end end
        for (int i = 0; i < 11000; i++) begin step(); if (tx_b == 1'b1) begin t1 = cyc; break; end end
        for (int i = 0; i < 11000; i++) begin step(); if (tx_b == 1'b0) begin t2 = cyc; break; end end
        chk("b_latency", 32'(t0 - e), 32'd2);
        chk("b_start_len", 32'(t1 - t0), 32'(CPB_B));
        chk("b_bit0_len", 32'(t2 - t1), 32'(CPB_B));

        // 'a' then 'z' three cycles apart: second start bit follows the stop bit directly.
        do_reset(2);
        data_s = 8'h61; push_s = 1'b1;
        step();
        e = cyc;
        step(); step();
        data_s = 8'h7A; push_s = 1'b1;
        step();
        target = e + 2 + FL - 1;
        for (int k = 0; k < 3*FL && cyc < target; k++) step();
        chk("az_stop_before", 32'(tx_s), 32'd1);
        step();
        chk("az_second_start", 32'(tx_s), 32'd0);
        for (int k = 0; k < FL + 5; k++) step();
        chk("az_idle_busy", 32'(busy_s), 32'd0);

        // Ten back-to-back pushes: first pops after one edge, tenth is dropped.
        do_reset(2);
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            data_s = 8'h30 + 8'(i); push_s = 1'b1;
            step();
            if (int'(cnt_s) > peak) peak = int'(cnt_s);
        end
        chk("burst_peak", 32'(peak), 32'd8);
        chk("burst_full", 32'(full_s), 32'd1);
        chk("burst_ovf", 32'(ovf_s), 32'd1);
        for (int k = 0; k < 9*FL + 10; k++) step();
        chk("burst_drained", 32'(busy_s), 32'd0);

        // Full FIFO with a push on the exact edge the stop bit ends and pops.
        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            data_s = 8'h30 + 8'(i); push_s = 1'b1;
            step();
        end
        chk("pp_full", 32'(full_s), 32'd1);
        for (int k = 0; k < FL + 5 && cyc + 1 != m_fs + FL; k++) step();
        data_s = 8'h5A; push_s = 1'b1;
        step();
        chk("pp_count", 32'(cnt_s), 32'd8);
        chk("pp_ovf", 32'(ovf_s), 32'd0);

        // Reset in the middle of data bit 4, then confirm the line stays idle.
        for (int k = 0; k < FL + 5 && (cyc - m_fs) != 5*CPB_S + 3; k++) step();
        do_reset(3);
        for (int k = 0; k < 3*FL; k++) begin
            step();
            if (tx_s !== 1'b1) begin chk("post_rst_idle", 32'(tx_s), 32'd1); break; end
        end
        chk("post_rst_busy", 32'(busy_s), 32'd0);

        // Randomized traffic: sparse, then overloading, then drain.
        for (int k = 0; k < 400; k++) begin
            push_s = ($urandom_range(0, 11) == 0);
            data_s = 8'($urandom);
            step();
        end
        for (int k = 0; k < 150; k++) begin
            push_s = ($urandom_range(0, 1) == 0);
            data_s = 8'($urandom);
            step();
        end
        for (int k = 0; k < 10*FL; k++) step();
        chk("rand_drained", 32'(busy_s), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
